// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on valid/ready and shifts it out MSB first.
// Optional macro PARITY_SERIAL_EN appends an even-parity bit after the LSB of every frame.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] par_i,
    input  logic             par_valid_i,
    output logic             par_ready_o,
    output logic             x_o,
    output logic             x_valid_o,
    output logic             x_first_o,
    output logic             x_last_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
`ifdef PARITY_SERIAL_EN
        S_PAR   = 2'd2,
`endif
        S_SHIFT = 2'd1
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_x;
    logic               r_valid;
    logic               r_first;
    logic               r_last;
    logic               w_ready;
    logic               w_load;
`ifdef PARITY_SERIAL_EN
    logic               r_par;
`endif

    // Ready opens on the cycle that shows the final bit of a frame so the next MSB follows with no gap.
    always_comb begin
        w_ready = 1'b0;
        w_next  = r_state;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
            end
            S_SHIFT: begin
`ifndef PARITY_SERIAL_EN
                w_ready = (r_cnt == '0);
`endif
            end
`ifdef PARITY_SERIAL_EN
            S_PAR: begin
                w_ready = 1'b1;
            end
`endif
            default: begin
                w_ready = 1'b0;
            end
        endcase

        w_load = par_valid_i & w_ready;

        case (r_state)
            S_IDLE: begin
                if (w_load) w_next = S_SHIFT;
            end
            S_SHIFT: begin
                if (r_cnt == '0) begin
`ifdef PARITY_SERIAL_EN
                    w_next = S_PAR;
`else
                    w_next = w_load ? S_SHIFT : S_IDLE;
`endif
                end
            end
`ifdef PARITY_SERIAL_EN
            S_PAR: begin
                w_next = w_load ? S_SHIFT : S_IDLE;
            end
`endif
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The MSB goes straight to the output register on load; r_shift keeps the remaining bits left-aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
            r_x     <= 1'b0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
`ifdef PARITY_SERIAL_EN
            r_par   <= 1'b0;
`endif
        end else if (w_load) begin
            r_shift <= {par_i[WIDTH-2:0], 1'b0};
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_x     <= par_i[WIDTH-1];
            r_valid <= 1'b1;
            r_first <= 1'b1;
            r_last  <= 1'b0;
`ifdef PARITY_SERIAL_EN
            r_par   <= ^par_i;
`endif
        end else if (r_state == S_SHIFT && r_cnt != '0) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt - CNT_W'(1);
            r_x     <= r_shift[WIDTH-1];
            r_first <= 1'b0;
`ifdef PARITY_SERIAL_EN
            r_last  <= 1'b0;
`else
            r_last  <= (r_cnt == CNT_W'(1));
`endif
`ifdef PARITY_SERIAL_EN
        end else if (r_state == S_SHIFT) begin
            r_x     <= r_par;
            r_first <= 1'b0;
            r_last  <= 1'b1;
`endif
        end else begin
            // Frame finished with no new word: drop valid but keep x_o steady.
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
        end
    end

    assign par_ready_o = w_ready;
    assign x_o         = r_x;
    assign x_valid_o   = r_valid;
    assign x_first_o   = r_first;
    assign x_last_o    = r_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: a queue-based bit-stream model plus a SIPO loopback receiver.
// Build with +define+PARITY_SERIAL_EN to exercise the parity frame format.
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PARITY_SERIAL_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int RXW = W + PB;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] par_i;
    logic         par_valid_i;
    logic         par_ready_o;
    logic         x_o;
    logic         x_valid_o;
    logic         x_first_o;
    logic         x_last_o;

    piso_serializer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .par_i       (par_i),
        .par_valid_i (par_valid_i),
        .par_ready_o (par_ready_o),
        .x_o         (x_o),
        .x_valid_o   (x_valid_o),
        .x_first_o   (x_first_o),
        .x_last_o    (x_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic x;
        logic f;
        logic l;
    } sbit_t;

    sbit_t            bits_q[$];
    logic [RXW-1:0]   sent_q[$];
    logic             m_x, m_valid, m_first, m_last;
    logic [RXW-1:0]   rx;
    int               n_checks;
    int               n_errors;
    int               n_acc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Frame as the link defines it: MSB first, optional even parity, first/last markers.
    task automatic push_frame(input logic [W-1:0] w);
        sbit_t b;
        for (int i = W - 1; i >= 0; i--) begin
            b.x = w[i];
            b.f = (i == W - 1);
            b.l = (PB == 0) && (i == 0);
            bits_q.push_back(b);
        end
`ifdef PARITY_SERIAL_EN
        b.x = ^w;
        b.f = 1'b0;
        b.l = 1'b1;
        bits_q.push_back(b);
        sent_q.push_back({w, ^w});
`else
        sent_q.push_back(w);
`endif
    endtask

    task automatic model_reset();
        bits_q.delete();
        sent_q.delete();
        m_x = 1'b0;
        m_valid = 1'b0;
        m_first = 1'b0;
        m_last = 1'b0;
        rx = '0;
    endtask

    // One clock: check outputs at the falling edge, drive inputs, advance the model at the rising edge.
    task automatic step(input logic v, input logic [W-1:0] d);
        logic  acc;
        sbit_t b;
        @(negedge clk);
        chk("x_valid", 32'(x_valid_o), 32'(m_valid));
        chk("x_o", 32'(x_o), 32'(m_x));
        chk("x_first", 32'(x_first_o), 32'(m_first));
        chk("x_last", 32'(x_last_o), 32'(m_last));
        chk("ready", 32'(par_ready_o), 32'(bits_q.size() == 0));
        if (x_valid_o) rx = {rx[RXW-2:0], x_o};
        if (x_valid_o && x_last_o) begin
            if (sent_q.size() > 0) chk("loopback", 32'(rx), 32'(sent_q.pop_front()));
            else chk("loopback_extra", 32'(sent_q.size()), 32'd1);
        end
        par_valid_i = v;
        par_i = d;
        acc = v && (bits_q.size() == 0);
        @(posedge clk);
        if (acc) begin
            push_frame(d);
            n_acc++;
        end
        if (bits_q.size() > 0) begin
            b = bits_q.pop_front();
            m_x = b.x;
            m_first = b.f;
            m_last = b.l;
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
            m_first = 1'b0;
            m_last = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_acc = 0;
        model_reset();
        reset_n = 1'b0;
        par_valid_i = 1'b0;
        par_i = '0;
        #3;
        chk("rst_x", 32'(x_o), 32'd0);
        chk("rst_valid", 32'(x_valid_o), 32'd0);
        chk("rst_ready", 32'(par_ready_o), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Single word, then idle
        step(1'b1, 4'b1011);
        repeat (6) step(1'b0, 4'h0);

        // Back-to-back words with valid held high
        step(1'b1, 4'hA);
        repeat (3) step(1'b1, 4'h5);
        repeat (4) step(1'b1, 4'h3);
        repeat (5) step(1'b0, 4'h0);

        // Backpressure: 4'hF offered while busy, replaced by 4'h0 before ready returns
        step(1'b1, 4'h9);
        repeat (2) step(1'b1, 4'hF);
        repeat (PB + 1) step(1'b1, 4'h0);
        repeat (8) step(1'b0, 4'hF);

`ifdef PARITY_SERIAL_EN
        step(1'b1, 4'b0111);
        repeat (6) step(1'b0, 4'h0);
        step(1'b1, 4'b0110);
        repeat (6) step(1'b0, 4'h0);
`endif

        // Reset asserted mid-frame acts immediately
        step(1'b1, 4'hC);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_x", 32'(x_o), 32'd0);
        chk("mid_rst_valid", 32'(x_valid_o), 32'd0);
        chk("mid_rst_first", 32'(x_first_o), 32'd0);
        chk("mid_rst_last", 32'(x_last_o), 32'd0);
        chk("mid_rst_ready", 32'(par_ready_o), 32'd1);
        model_reset();
        step(1'b0, 4'h0);
        #2 reset_n = 1'b1;
        repeat (6) step(1'b0, 4'h0);

        // Randomized stream for the loopback receiver
        n_acc = 0;
        for (int c = 0; c < 4000 && n_acc < 200; c++) begin
            step($urandom_range(0, 3) != 0, W'($urandom));
        end
        chk("acc_budget", 32'(n_acc), 32'd200);
        repeat (W + 3) step(1'b0, 4'h0);
        chk("sent_drained", 32'(sent_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
